// File: rtl/weight_update_unit.sv
// Serial gradient-descent weight update: one shared multiplier walks the eight
// weights over eight cycles, then publishes the new vector with a done pulse.
module weight_update_unit #(
    parameter int LR_SHIFT = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [22:0]      final_i,
    input  logic [3:0]       target_i,
    input  logic [63:0]      weights_i,
    input  logic [9:0]       x0_i,
    input  logic [9:0]       x1_i,
    input  logic [9:0]       x2_i,
    input  logic [9:0]       x3_i,
    input  logic [9:0]       x4_i,
    input  logic [9:0]       x5_i,
    input  logic [9:0]       x6_i,
    input  logic [9:0]       x7_i,
    output logic [63:0]      weights_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] update_cnt_o
);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [22:0] final_q;
    logic [3:0]  target_q;
    logic [7:0]  w_q [8];
    logic [9:0]  x_q [8];
    logic [9:0]  x_in [8];

    logic signed [23:0] err;
    logic signed [34:0] prod;
    logic signed [34:0] delta;
    logic signed [35:0] wn;
    logic [7:0]         w_new;
    logic [63:0]        w_vec_next;

    always_comb begin
        x_in[0] = x0_i;
        x_in[1] = x1_i;
        x_in[2] = x2_i;
        x_in[3] = x3_i;
        x_in[4] = x4_i;
        x_in[5] = x5_i;
        x_in[6] = x6_i;
        x_in[7] = x7_i;
    end

    // Single multiplier shared across lanes, steered by idx.
    always_comb begin
        err   = $signed({1'b0, final_q}) - $signed({20'b0, target_q});
        prod  = err * $signed({1'b0, x_q[idx]});
        delta = prod >>> LR_SHIFT;
        wn    = $signed({28'b0, w_q[idx]}) - $signed({delta[34], delta});
        if (wn[35])
            w_new = 8'h00;
        else if (|wn[34:8])
            w_new = 8'hFF;
        else
            w_new = wn[7:0];
    end

    // Working vector with the current lane replaced, so lane 7 is included on publish.
    always_comb begin
        w_vec_next = '0;
        for (int unsigned k = 0; k < 8; k++)
            w_vec_next[k*8 +: 8] = (idx == 3'(k)) ? w_new : w_q[k];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            final_q      <= '0;
            target_q     <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                w_q[k] <= '0;
                x_q[k] <= '0;
            end
            weights_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            update_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        final_q  <= final_i;
                        target_q <= target_i;
                        for (int unsigned k = 0; k < 8; k++) begin
                            w_q[k] <= weights_i[k*8 +: 8];
                            x_q[k] <= x_in[k];
                        end
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= UPDATE;
                    end
                end
                UPDATE: begin
                    w_q[idx] <= w_new;
                    idx      <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        weights_o <= w_vec_next;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    if (update_cnt_o != '1)
                        update_cnt_o <= update_cnt_o + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_unit.sv
// Directed-plus-random bench for weight_update_unit against an integer
// arithmetic model of the gradient step.
module tb_weight_update_unit;

    localparam int LR_SHIFT = 10;
    localparam int CNT_W    = 8;
    localparam longint SCALE = longint'(1) << LR_SHIFT;

    typedef logic [9:0] xarr_t [8];

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [22:0]      final_i;
    logic [3:0]       target_i;
    logic [63:0]      weights_i;
    xarr_t            x;
    logic [63:0]      weights_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] update_cnt_o;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] exp_w;
    int          exp_cnt;

    weight_update_unit #(.LR_SHIFT(LR_SHIFT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .final_i(final_i), .target_i(target_i), .weights_i(weights_i),
        .x0_i(x[0]), .x1_i(x[1]), .x2_i(x[2]), .x3_i(x[3]),
        .x4_i(x[4]), .x5_i(x[5]), .x6_i(x[6]), .x7_i(x[7]),
        .weights_o(weights_o), .busy_o(busy_o), .done_o(done_o),
        .update_cnt_o(update_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gradient step with explicit floor division and clamping.
    function automatic logic [63:0] model(int unsigned f, int unsigned t,
                                          logic [63:0] w, xarr_t xs);
        logic [63:0] r;
        longint err, p, d, n;
        r = '0;
        err = longint'(f) - longint'(t);
        for (int k = 0; k < 8; k++) begin
            p = err * longint'(xs[k]);
            if (p >= 0) d = p / SCALE;
            else        d = -((-p + SCALE - 1) / SCALE);
            n = longint'(w[k*8 +: 8]) - d;
            if (n < 0)        r[k*8 +: 8] = 8'h00;
            else if (n > 255) r[k*8 +: 8] = 8'hFF;
            else              r[k*8 +: 8] = 8'(n);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [79:0] obs, logic [79:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(string tag, logic [63:0] ew, logic eb, logic ed, int ec);
        chk(tag, {6'b0, weights_o, busy_o, done_o, update_cnt_o},
                 {6'b0, ew, eb, ed, CNT_W'(ec)});
    endtask

    task automatic randomize_inputs();
        final_i   = 23'($urandom);
        target_i  = 4'($urandom);
        weights_i = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) x[k] = 10'($urandom);
    endtask

    // One full pass from start pulse to return to IDLE; inputs scrambled after capture.
    task automatic do_pass(string tag);
        logic [63:0] exp_new;
        exp_new = model(final_i, target_i, weights_i, x);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        randomize_inputs();
        chk_all({tag, "_e0"}, exp_w, 1'b1, 1'b0, exp_cnt);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all({tag, "_busy"}, exp_w, 1'b1, 1'b0, exp_cnt);
        end
        tick();
        exp_w = exp_new;
        chk_all({tag, "_done"}, exp_w, 1'b0, 1'b1, exp_cnt);
        tick();
        exp_cnt++;
        chk_all({tag, "_idle"}, exp_w, 1'b0, 1'b0, exp_cnt);
    endtask

    initial begin
        logic [63:0] wsave, wA, wB;
        int base;

        rst_i = 1'b0;
        start_i = 1'b1;
        randomize_inputs();
        exp_w = '0;
        exp_cnt = 0;
        tick();
        tick();
        chk_all("reset_prio", '0, 1'b0, 1'b0, 0);
        rst_i = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("idle", '0, 1'b0, 1'b0, 0);
        end

        // Positive error, uniform lanes.
        weights_i = {8{8'h40}};
        for (int k = 0; k < 8; k++) x[k] = 10'd256;
        final_i = 23'd20;
        target_i = 4'd4;
        do_pass("pos");
        chk("pos_const", {16'b0, weights_o}, {16'b0, 64'h3C3C3C3C3C3C3C3C});

        // Saturation at both ends; unused lanes have x=0.
        wsave = {$urandom, $urandom};
        wsave[15:0] = 16'hFA40;
        weights_i = wsave;
        for (int k = 0; k < 8; k++) x[k] = 10'd0;
        x[0] = 10'd256;
        final_i = 23'd1000;
        target_i = 4'd8;
        do_pass("sat_lo");
        chk("sat_lo_w0", {72'b0, weights_o[7:0]}, 80'h00);
        weights_i = wsave;
        for (int k = 0; k < 8; k++) x[k] = 10'd0;
        x[1] = 10'd1023;
        final_i = 23'd0;
        target_i = 4'd15;
        do_pass("sat_hi");
        chk("sat_hi_w1", {72'b0, weights_o[15:8]}, 80'hFF);
        chk("sat_hi_rest", {16'b0, weights_o[63:16], 16'b0}, {16'b0, wsave[63:16], 16'b0});

        // Zero error leaves every weight untouched.
        randomize_inputs();
        final_i = 23'd9;
        target_i = 4'd9;
        wsave = weights_i;
        do_pass("zero_err");
        chk("zero_err_w", {16'b0, weights_o}, {16'b0, wsave});

        // Random passes mixing moderate and full-range predictions.
        for (int r = 0; r < 6; r++) begin
            randomize_inputs();
            if (r % 2 == 0) final_i = 23'($urandom_range(0, 3000));
            do_pass("rand");
        end

        // start_i held high: accepts every 10 cycles, final_i change seen only by later passes.
        randomize_inputs();
        final_i = 23'($urandom_range(0, 3000));
        wA = model(final_i, target_i, weights_i, x);
        wB = wA;
        base = exp_cnt;
        start_i = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 3) begin
                final_i = final_i + 23'd500;
                wB = model(final_i, target_i, weights_i, x);
            end
            chk_all("hold", (e < 8) ? exp_w : (e < 18) ? wA : wB,
                    (e % 10) <= 7, (e % 10) == 8, base + (e + 1) / 10);
        end
        start_i = 1'b0;
        exp_w = wB;
        exp_cnt = base + 3;
        chk("hold_cnt", {72'b0, update_cnt_o}, 80'(CNT_W'(base + 3)));

        // Reset in the middle of a pass.
        randomize_inputs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        exp_w = '0;
        exp_cnt = 0;
        chk_all("midrst_e4", '0, 1'b0, 1'b0, 0);
        tick();
        chk_all("midrst_e5", '0, 1'b0, 1'b0, 0);
        randomize_inputs();
        final_i = 23'($urandom_range(0, 3000));
        do_pass("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
